// File: rtl/fetch_queue.sv
// fetch_queue: two-entry instruction fetch queue between the PC stage, a synchronous ROM and decode.
// Rev 1.0 - initial release.
`default_nettype none

module fetch_queue (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  output logic        stop,
  input  logic        flush,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        dec_ready
);

  localparam int unsigned DEPTH = 2;

  logic [31:0] r_ent_pc   [DEPTH];
  logic [31:0] r_ent_inst [DEPTH];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic        r_pend;
  logic [31:0] r_pend_pc;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic        w_room;

  assign inst_valid = (r_count != 2'd0);
  assign inst_out   = r_ent_inst[r_rd_ptr];
  assign inst_pc    = r_ent_pc[r_rd_ptr];
  assign w_pop      = inst_valid & dec_ready;

  // A slot is free when stored entries plus the read in flight leave room,
  // or when decode frees one this cycle.
  assign w_room  = ({1'b0, r_count} + {2'b00, r_pend}) < 3'd2;
  assign w_issue = rst & ~flush & (w_room | w_pop);
  assign w_push  = r_pend & ~flush;

  assign imem_en   = w_issue;
  assign imem_addr = pc_addr;
  assign stop      = rst & ~flush & ~w_issue;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_pend    <= 1'b0;
      r_pend_pc <= 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ent_pc[i]   <= 32'd0;
        r_ent_inst[i] <= 32'd0;
      end
    end else if (flush) begin
      // Redirect: drop stored entries and whatever the ROM returns this cycle.
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_pend   <= 1'b0;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_pc <= pc_addr;
      end
      if (w_push) begin
        r_ent_pc[r_wr_ptr]   <= r_pend_pc;
        r_ent_inst[r_wr_ptr] <= imem_rdata;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire
